// File: rtl/mp_regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mp_regfile_pkg                                             |
// | Description : Shared sizes and types for the multi-port register file.   |
// | Revision    : 1.0 - initial N-read / M-write release                     |
// +--------------------------------------------------------------------------+
package mp_regfile_pkg;

  localparam int REGFILE_NREGS  = 32;
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_NREAD  = 3;
  localparam int REGFILE_NWRITE = 2;
  localparam int REGFILE_SEL_W  = $clog2(REGFILE_NREGS);

  typedef logic [REGFILE_SEL_W-1:0]  regbits_t;
  typedef logic [REGFILE_DATA_W-1:0] word_t;

endpackage : mp_regfile_pkg
`default_nettype wire

// File: rtl/mp_regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mp_regfile_if                                              |
// | Description : Read, writeback and issue signals of the register file.    |
// | Revision    : 1.0 - initial N-read / M-write release                     |
// +--------------------------------------------------------------------------+
interface mp_regfile_if
  import mp_regfile_pkg::*;
#(
  parameter int NREGS  = REGFILE_NREGS,
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int NREAD  = REGFILE_NREAD,
  parameter int NWRITE = REGFILE_NWRITE
) ();

  localparam int SEL_W = $clog2(NREGS);

  logic [NREAD-1:0][SEL_W-1:0]   rsel;
  logic [NREAD-1:0][DATA_W-1:0]  rdat;
  logic [NREAD-1:0]              rbusy;
  logic [NWRITE-1:0]             WEN;
  logic [NWRITE-1:0][SEL_W-1:0]  wsel;
  logic [NWRITE-1:0][DATA_W-1:0] wdata;
  logic                          issue_en;
  logic [SEL_W-1:0]              issue_rd;
  logic                          issue_ok;

  modport rf (
    input  rsel, WEN, wsel, wdata, issue_en, issue_rd,
    output rdat, rbusy, issue_ok
  );

  modport tb (
    output rsel, WEN, wsel, wdata, issue_en, issue_rd,
    input  rdat, rbusy, issue_ok
  );

  modport slave (
    input  rsel, WEN, wsel, wdata, issue_en, issue_rd,
    output rdat, rbusy, issue_ok
  );

  modport master (
    output rsel, WEN, wsel, wdata, issue_en, issue_rd,
    input  rdat, rbusy, issue_ok
  );

endinterface : mp_regfile_if
`default_nettype wire

// File: rtl/mp_regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mp_regfile_scoreboard                                      |
// | Description : Per-register pending-writeback bits, operand readiness and |
// |               WAW issue check.                                           |
// | Revision    : 1.0 - initial N-read / M-write release                     |
// +--------------------------------------------------------------------------+
module mp_regfile_scoreboard
  import mp_regfile_pkg::*;
#(
  parameter int NREGS  = REGFILE_NREGS,
  parameter int NREAD  = REGFILE_NREAD,
  parameter int NWRITE = REGFILE_NWRITE,
  parameter int SEL_W  = $clog2(NREGS)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NREAD-1:0][SEL_W-1:0]  rsel,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE-1:0][SEL_W-1:0] wsel,
  input  logic                         issue_en,
  input  logic [SEL_W-1:0]             issue_rd,
  output logic [NREAD-1:0]             rbusy,
  output logic                         issue_ok
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [NREAD-1:0] w_rbusy;
  logic             w_issue_hit;
  logic             w_issue_ok;

  // A writeback landing this cycle on the destination resolves the WAW hazard.
  always_comb begin
    w_issue_hit = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && (wsel[j] == issue_rd)) begin
        w_issue_hit = 1'b1;
      end
    end
    w_issue_ok = !nRST || (issue_rd == '0) || !r_busy[issue_rd] || w_issue_hit;
  end

  // Clears first, then the set, so a new producer outlives a same-cycle writeback.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) begin
        w_busy_nxt[wsel[j]] = 1'b0;
      end
    end
    if (issue_en && w_issue_ok && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      w_rbusy[i] = nRST && r_busy[rsel[i]];
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (wsel[j] == rsel[i])) begin
          w_rbusy[i] = 1'b0;
        end
      end
    end
  end

  assign rbusy    = w_rbusy;
  assign issue_ok = w_issue_ok;

endmodule : mp_regfile_scoreboard
`default_nettype wire

// File: rtl/mp_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mp_regfile                                                 |
// | Description : N-read / M-write register file with same-cycle bypass and  |
// |               busy-bit scoreboard; r0 reads as zero.                     |
// | Revision    : 1.0 - initial N-read / M-write release                     |
// +--------------------------------------------------------------------------+
module mp_regfile
  import mp_regfile_pkg::*;
#(
  parameter int NREGS  = REGFILE_NREGS,
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int NREAD  = REGFILE_NREAD,
  parameter int NWRITE = REGFILE_NWRITE
) (
  input  logic     CLK,
  input  logic     nRST,
  mp_regfile_if.rf bus
);

  localparam int SEL_W = $clog2(NREGS);

  logic [DATA_W-1:0]            r_regs [NREGS];
  logic [NREAD-1:0][DATA_W-1:0] w_rdat;

  // Later ports overwrite earlier ones, giving the highest index priority.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (bus.WEN[j] && (bus.wsel[j] != '0)) begin
          r_regs[bus.wsel[j]] <= bus.wdata[j];
        end
      end
    end
  end

  // Reads are forced to zero while reset is asserted, even against a live bypass.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      w_rdat[i] = '0;
      if (nRST && (bus.rsel[i] != '0)) begin
        w_rdat[i] = r_regs[bus.rsel[i]];
        for (int j = 0; j < NWRITE; j++) begin
          if (bus.WEN[j] && (bus.wsel[j] == bus.rsel[i])) begin
            w_rdat[i] = bus.wdata[j];
          end
        end
      end
    end
  end

  assign bus.rdat = w_rdat;

  mp_regfile_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .SEL_W  (SEL_W)
  ) u_scoreboard (
    .CLK      (CLK),
    .nRST     (nRST),
    .rsel     (bus.rsel),
    .wen      (bus.WEN),
    .wsel     (bus.wsel),
    .issue_en (bus.issue_en),
    .issue_rd (bus.issue_rd),
    .rbusy    (bus.rbusy),
    .issue_ok (bus.issue_ok)
  );

endmodule : mp_regfile
`default_nettype wire

// File: tb/tb_mp_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mp_regfile                                              |
// | Description : Vector table plus reset sequences for mp_regfile.          |
// | Revision    : 1.0 - initial N-read / M-write release                     |
// +--------------------------------------------------------------------------+
module tb_mp_regfile;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  mp_regfile_if bus ();

  mp_regfile dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 rdat, 1 rbusy, 2 issue_ok
    int          port;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]       wen;
    logic [1:0][4:0]  ws;
    logic [1:0][31:0] wd;
    logic             ien;
    logic [4:0]       ird;
    logic [2:0][4:0]  rs;
    logic [2:0][31:0] er;
    logic [2:0]       eb;
    logic             eok;
  } vec_t;

  localparam int NVEC = 15;

  exp_t sbq[$];
  vec_t vecs [NVEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic [1:0] wen, logic [4:0] ws0, logic [31:0] wd0,
                              logic [4:0] ws1, logic [31:0] wd1, logic ien, logic [4:0] ird,
                              logic [4:0] rs0, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                              logic [2:0] eb, logic eok);
    vec_t v;
    v.wen = wen;  v.ws[0] = ws0; v.wd[0] = wd0; v.ws[1] = ws1; v.wd[1] = wd1;
    v.ien = ien;  v.ird = ird;
    v.rs[0] = rs0; v.rs[1] = rs1; v.rs[2] = rs2;
    v.er[0] = e0;  v.er[1] = e1;  v.er[2] = e2;
    v.eb = eb;     v.eok = eok;
    return v;
  endfunction

  function automatic logic [31:0] actual(int kind, int port);
    case (kind)
      0:       return bus.rdat[port];
      1:       return {31'b0, bus.rbusy[port]};
      default: return {31'b0, bus.issue_ok};
    endcase
  endfunction

  task automatic push(string name, int kind, int port, logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.port = port; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic expect_all(string tag, logic [31:0] r0, logic [31:0] r1, logic [31:0] r2,
                            logic b0, logic b1, logic b2, logic ok);
    push({tag, "_rdat0"}, 0, 0, r0);
    push({tag, "_rdat1"}, 0, 1, r1);
    push({tag, "_rdat2"}, 0, 2, r2);
    push({tag, "_rbusy0"}, 1, 0, {31'b0, b0});
    push({tag, "_rbusy1"}, 1, 1, {31'b0, b1});
    push({tag, "_rbusy2"}, 1, 2, {31'b0, b2});
    push({tag, "_issue_ok"}, 2, 0, {31'b0, ok});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = actual(e.kind, e.port);
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  endtask

  initial begin
    // Reset held while every writeback port hammers all-ones into selected registers.
    nRST         = 1'b0;
    bus.WEN      = 2'b11;
    bus.wsel[0]  = 5'd1;
    bus.wsel[1]  = 5'd2;
    bus.wdata[0] = 32'hFFFF_FFFF;
    bus.wdata[1] = 32'hFFFF_FFFF;
    bus.rsel[0]  = 5'd1;
    bus.rsel[1]  = 5'd2;
    bus.rsel[2]  = 5'd3;
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd1;

    vecs[0]  = mk(2'b11, 5'd5, 32'hAAAA, 5'd5, 32'hBBBB, 1'b0, 5'd0,
                  5'd5, 5'd0, 5'd0, 32'hBBBB, 32'h0, 32'h0, 3'b000, 1'b1);
    vecs[1]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                  5'd5, 5'd0, 5'd0, 32'hBBBB, 32'h0, 32'h0, 3'b000, 1'b1);
    vecs[2]  = mk(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd0,
                  5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1);
    vecs[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                  5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1);
    vecs[4]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7,
                  5'd0, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1);
    vecs[5]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7,
                  5'd0, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0, 3'b010, 1'b0);
    vecs[6]  = mk(2'b01, 5'd7, 32'h42, 5'd0, 32'h0, 1'b0, 5'd7,
                  5'd0, 5'd7, 5'd7, 32'h0, 32'h42, 32'h42, 3'b000, 1'b1);
    vecs[7]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd7,
                  5'd7, 5'd7, 5'd0, 32'h42, 32'h42, 32'h0, 3'b000, 1'b1);
    vecs[8]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9,
                  5'd9, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1);
    vecs[9]  = mk(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b1, 5'd9,
                  5'd9, 5'd9, 5'd0, 32'h99, 32'h99, 32'h0, 3'b000, 1'b1);
    vecs[10] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9,
                  5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 3'b001, 1'b0);
    vecs[11] = mk(2'b01, 5'd9, 32'h5, 5'd0, 32'h0, 1'b0, 5'd9,
                  5'd9, 5'd0, 5'd0, 32'h5, 32'h0, 32'h0, 3'b000, 1'b1);
    vecs[12] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9,
                  5'd9, 5'd5, 5'd7, 32'h5, 32'hBBBB, 32'h42, 3'b000, 1'b1);
    vecs[13] = mk(2'b11, 5'd3, 32'h77, 5'd31, 32'hDEAD_BEEF, 1'b1, 5'd3,
                  5'd3, 5'd31, 5'd30, 32'h77, 32'hDEAD_BEEF, 32'h0, 3'b000, 1'b1);
    vecs[14] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd3,
                  5'd3, 5'd31, 5'd0, 32'h77, 32'hDEAD_BEEF, 32'h0, 3'b001, 1'b0);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    expect_all("in_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    @(posedge CLK); #1;
    nRST         = 1'b1;
    bus.WEN      = 2'b00;
    bus.issue_en = 1'b0;
    @(negedge CLK);
    expect_all("post_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    for (int v = 0; v < NVEC; v++) begin
      @(posedge CLK); #1;
      bus.WEN      = vecs[v].wen;
      bus.wsel     = vecs[v].ws;
      bus.wdata    = vecs[v].wd;
      bus.issue_en = vecs[v].ien;
      bus.issue_rd = vecs[v].ird;
      bus.rsel     = vecs[v].rs;
      expect_all($sformatf("vec%0d", v), vecs[v].er[0], vecs[v].er[1], vecs[v].er[2],
                 vecs[v].eb[0], vecs[v].eb[1], vecs[v].eb[2], vecs[v].eok);
      @(negedge CLK);
      drain();
    end

    // r3 is busy holding 0x77; reset dropped between edges must clear at once.
    #2;
    nRST = 1'b0;
    #1;
    expect_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    expect_all("after_async", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mp_regfile
`default_nettype wire
